note_tone_gen: RTL and testbench

- Parametrised musical tone generator: produces a square wave for any of 12 chromatic notes over 4 octaves, derived from the system clock by integer division.
- Supersedes per-note fixed dividers: one instance drives the speaker pin.
- A sequencer or keypad decoder feeds notes via a valid/ready handshake.
- Note changes are glitch-free; the new note is applied only at a period boundary.

---
 rtl/note_pkg.sv | 45 ++++
 rtl/note_div_rom.sv | 37 +++
 rtl/note_tone_gen.sv | 85 ++++++++
 tb/tb_note_tone_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - note codes, octave-4 frequency table, divisor rounding and duty codes
package note_pkg;

    typedef enum logic [3:0] {
        NOTE_C    = 4'd0,
        NOTE_CS   = 4'd1,
        NOTE_D    = 4'd2,
        NOTE_DS   = 4'd3,
        NOTE_E    = 4'd4,
        NOTE_F    = 4'd5,
        NOTE_FS   = 4'd6,
        NOTE_G    = 4'd7,
        NOTE_GS   = 4'd8,
        NOTE_A    = 4'd9,
        NOTE_AS   = 4'd10,
        NOTE_B    = 4'd11,
        NOTE_REST = 4'd12
    } note_e;

    typedef enum logic [1:0] {
        DUTY_50 = 2'd0,
        DUTY_25 = 2'd1,
        DUTY_12 = 2'd2,
        DUTY_75 = 2'd3
    } duty_e;

    localparam int unsigned NUM_NOTES = 12;

    // Octave-4 frequencies in centihertz, C..B
    localparam int unsigned FREQ_CHZ [NUM_NOTES] = '{
        26163, 27718, 29366, 31113, 32963, 34923,
        36999, 39200, 41530, 44000, 46616, 49388
    };

    function automatic longint unsigned round_div(input longint unsigned num,
                                                  input longint unsigned den);
        return (num + den / 2) / den;
    endfunction

    function automatic longint unsigned note_base_div(input longint unsigned clk_hz,
                                                      input int unsigned n);
        return round_div(clk_hz * 100, longint'(FREQ_CHZ[n]));
    endfunction

endpackage

// File: rtl/note_div_rom.sv
// rtl/note_div_rom.sv - combinational {note, octave, duty} to divisor and high-time map
module note_div_rom #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          CNT_W  = 28,
    parameter int          OCT_W  = 2
) (
    input  logic [3:0]       note,
    input  logic [OCT_W-1:0] octave,
    input  logic [1:0]       duty,
    output logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] high_time
);
    import note_pkg::*;

    // Codes 12..15 map to 0 so REST and out-of-range codes need no special decode
    localparam logic [CNT_W-1:0] BASE_DIV [16] = '{
        CNT_W'(note_base_div(CLK_HZ, 0)),  CNT_W'(note_base_div(CLK_HZ, 1)),
        CNT_W'(note_base_div(CLK_HZ, 2)),  CNT_W'(note_base_div(CLK_HZ, 3)),
        CNT_W'(note_base_div(CLK_HZ, 4)),  CNT_W'(note_base_div(CLK_HZ, 5)),
        CNT_W'(note_base_div(CLK_HZ, 6)),  CNT_W'(note_base_div(CLK_HZ, 7)),
        CNT_W'(note_base_div(CLK_HZ, 8)),  CNT_W'(note_base_div(CLK_HZ, 9)),
        CNT_W'(note_base_div(CLK_HZ, 10)), CNT_W'(note_base_div(CLK_HZ, 11)),
        '0, '0, '0, '0
    };

    always_comb begin
        div       = BASE_DIV[note] >> octave;
        high_time = div >> 1;
        case (duty)
            DUTY_25: high_time = div >> 2;
            DUTY_12: high_time = div >> 3;
            DUTY_75: high_time = div - (div >> 2);
            default: high_time = div >> 1;
        endcase
    end

endmodule

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - glitch-free square-wave note generator; NOTE_TONE_DUTY_EN adds duty_sel
module note_tone_gen #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          CNT_W  = 28,
    parameter int          OCT_W  = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [3:0]       note_sel,
    input  logic [OCT_W-1:0] octave_sel,
`ifdef NOTE_TONE_DUTY_EN
    input  logic [1:0]       duty_sel,
`endif
    output logic             clock_out,
    output logic             period_tick
);
    import note_pkg::*;

    logic [3:0]       act_note, pend_note;
    logic [OCT_W-1:0] act_oct, pend_oct;
    logic [1:0]       act_duty, pend_duty, req_duty;
    logic             pending_full;
    logic [CNT_W-1:0] counter, div, high_time;
    logic             idle, boundary, transfer, apply;

`ifdef NOTE_TONE_DUTY_EN
    assign req_duty = duty_sel;
`else
    assign req_duty = DUTY_50;
`endif

    note_div_rom #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .OCT_W(OCT_W)) u_rom (
        .note      (act_note),
        .octave    (act_oct),
        .duty      (act_duty),
        .div       (div),
        .high_time (high_time)
    );

    assign idle       = !enable || (act_note >= NOTE_REST);
    assign boundary   = !idle && (counter == div - CNT_W'(1));
    assign note_ready = !pending_full;
    assign transfer   = note_valid && note_ready;
    // Transfer needs an empty slot, so a request can never be applied in its own cycle
    assign apply      = pending_full && (boundary || idle);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            act_note     <= NOTE_REST;
            act_oct      <= '0;
            act_duty     <= DUTY_50;
            pend_note    <= NOTE_REST;
            pend_oct     <= '0;
            pend_duty    <= DUTY_50;
            pending_full <= 1'b0;
            counter      <= '0;
            clock_out    <= 1'b0;
            period_tick  <= 1'b0;
        end else begin
            if (transfer) begin
                pend_note    <= note_sel;
                pend_oct     <= octave_sel;
                pend_duty    <= req_duty;
                pending_full <= 1'b1;
            end
            if (apply) begin
                act_note     <= pend_note;
                act_oct      <= pend_oct;
                act_duty     <= pend_duty;
                pending_full <= 1'b0;
                counter      <= '0;
            end else if (idle || boundary) begin
                counter <= '0;
            end else begin
                counter <= counter + CNT_W'(1);
            end
            clock_out   <= !idle && (counter < high_time);
            period_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// tb/tb_note_tone_gen.sv - directed self-checking bench for note_tone_gen at CLK_HZ=440_000
module tb_note_tone_gen;

    localparam int CNT_W = 28;
    localparam int OCT_W = 2;
    localparam int LIM   = 5000;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             note_valid;
    logic             note_ready;
    logic [3:0]       note_sel;
    logic [OCT_W-1:0] octave_sel;
`ifdef NOTE_TONE_DUTY_EN
    logic [1:0]       duty_sel;
`endif
    logic             clock_out;
    logic             period_tick;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    note_tone_gen #(.CLK_HZ(440_000), .CNT_W(CNT_W), .OCT_W(OCT_W)) dut (
        .clock_in    (clk),
        .reset       (reset),
        .enable      (enable),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_sel    (note_sel),
        .octave_sel  (octave_sel),
`ifdef NOTE_TONE_DUTY_EN
        .duty_sel    (duty_sel),
`endif
        .clock_out   (clock_out),
        .period_tick (period_tick)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; returns just after the accepting posedge, waits = stalled cycles
    task automatic load(input logic [3:0] n, input logic [OCT_W-1:0] o, input logic [1:0] d,
                        output int waits);
        note_sel   = n;
        octave_sel = o;
`ifdef NOTE_TONE_DUTY_EN
        duty_sel   = d;
`else
        if (d != 2'd0) $display("duty ignored in this build");
`endif
        note_valid = 1'b1;
        waits = 0;
        while (note_ready !== 1'b1 && waits < LIM) begin
            @(negedge clk);
            waits++;
        end
        if (note_ready !== 1'b1) waits = -1;
        else @(posedge clk);
        #1 note_valid = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_tick !== 1'b1 && n < LIM);
        if (period_tick !== 1'b1) n = -1;
    endtask

    task automatic tick_gap(output int n);
        wait_tick(n);
        wait_tick(n);
    endtask

    task automatic meas(output int hi, output int lo);
        int n;
        hi = -1;
        lo = -1;
        n  = 0;
        while (clock_out !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
        n = 0;
        while (clock_out !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        if (clock_out === 1'b1) begin
            hi = 0;
            while (clock_out === 1'b1 && hi < LIM) begin @(negedge clk); hi++; end
            lo = 0;
            while (clock_out === 1'b0 && lo < LIM) begin @(negedge clk); lo++; end
        end
    endtask

    initial begin
        int w, w2, n, hi, lo;
        reset      = 1'b1;
        enable     = 1'b1;
        note_valid = 1'b0;
        note_sel   = 4'd0;
        octave_sel = '0;
`ifdef NOTE_TONE_DUTY_EN
        duty_sel   = 2'd0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_clock_out", clock_out, 0);
        chk("rst_tick", period_tick, 0);
        chk("rst_ready", note_ready, 1);
        chk("rst_counter", dut.counter, 0);
        chk("rst_active", dut.act_note, 12);
        reset = 1'b0;
        @(negedge clk);

        // A4: 1000-cycle period
        load(4'd9, 2'd0, 2'd0, w);
        chk("a4_wait", w, 0);
        @(negedge clk);
        chk("a4_ready_low", note_ready, 0);
        @(negedge clk);
        chk("a4_ready_back", note_ready, 1);
        meas(hi, lo);
        chk("a4_high", hi, 500);
        chk("a4_low", lo, 500);
        tick_gap(n);
        chk("a4_tick_gap", n, 1000);
        chk("a4_tick_in_low", clock_out, 0);
        @(negedge clk);
        chk("a4_rise_after_tick", clock_out, 1);

        // A5 requested at counter 200: old period finishes first
        wait_tick(n);
        chk("a4_gap_from_1", n, 999);
        repeat (200) @(negedge clk);
        chk("a4_counter_200", dut.counter, 200);
        load(4'd9, 2'd1, 2'd0, w);
        chk("a5_wait", w, 0);
        wait_tick(n);
        chk("a5_apply_at_boundary", n, 800);
        meas(hi, lo);
        chk("a5_high", hi, 250);
        chk("a5_low", lo, 250);
        tick_gap(n);
        chk("a5_tick_gap", n, 500);

        // C4 even divisor, E4 odd divisor
        load(4'd0, 2'd0, 2'd0, w);
        wait_tick(n);
        meas(hi, lo);
        chk("c4_high", hi, 841);
        chk("c4_low", lo, 841);
        load(4'd4, 2'd0, 2'd0, w);
        wait_tick(n);
        meas(hi, lo);
        chk("e4_high", hi, 667);
        chk("e4_low", lo, 668);

        // Back-to-back requests: second stalls until the first is applied
        load(4'd9, 2'd0, 2'd0, w);
        chk("b2b_first_wait", w, 0);
        load(4'd0, 2'd1, 2'd0, w2);
        chk("b2b_second_stall", w2, 1334);
        wait_tick(n);
        chk("b2b_a4_full_period", n, 1000);
        meas(hi, lo);
        chk("c5_high", hi, 420);
        chk("c5_low", lo, 421);

        // enable drop at counter 300
        load(4'd9, 2'd0, 2'd0, w);
        wait_tick(n);
        repeat (300) @(negedge clk);
        chk("pre_drop_high", clock_out, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_clock_out", clock_out, 0);
        chk("drop_counter", dut.counter, 0);
        repeat (20) @(negedge clk);
        chk("drop_hold_out", clock_out, 0);
        chk("drop_hold_tick", period_tick, 0);
        enable = 1'b1;
        meas(hi, lo);
        chk("resume_high", hi, 500);
        chk("resume_low", lo, 500);

        // Out-of-range code acts as REST; leaving REST is immediate
        load(4'd14, 2'd0, 2'd0, w);
        wait_tick(n);
        chk("rest_enter_out", clock_out, 0);
        repeat (50) @(negedge clk);
        chk("rest_out", clock_out, 0);
        chk("rest_counter", dut.counter, 0);
        chk("rest_tick", period_tick, 0);
        load(4'd9, 2'd1, 2'd0, w);
        chk("rest_leave_wait", w, 0);
        @(negedge clk);
        chk("rest_leave_c0", clock_out, 0);
        @(negedge clk);
        chk("rest_leave_applied", dut.act_note, 9);
        @(negedge clk);
        chk("rest_leave_rise", clock_out, 1);
        meas(hi, lo);
        chk("rest_a5_high", hi, 250);
        chk("rest_a5_low", lo, 250);

        // Handshake while disabled: applied at once, sounds on enable
        enable = 1'b0;
        load(4'd9, 2'd0, 2'd0, w);
        @(negedge clk);
        @(negedge clk);
        chk("dis_pending_cleared", dut.pending_full, 0);
        chk("dis_oct_applied", dut.act_oct, 0);
        chk("dis_silent", clock_out, 0);
        enable = 1'b1;
        meas(hi, lo);
        chk("dis_a4_high", hi, 500);
        chk("dis_a4_low", lo, 500);

        // Reset mid-high
        repeat (100) @(negedge clk);
        chk("pre_reset_high", clock_out, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_out", clock_out, 0);
        chk("mid_rst_ready", note_ready, 1);
        chk("mid_rst_counter", dut.counter, 0);
        chk("mid_rst_active", dut.act_note, 12);
        chk("mid_rst_tick", period_tick, 0);
        reset = 1'b0;
        @(negedge clk);
        load(4'd9, 2'd0, 2'd0, w);
        meas(hi, lo);
        chk("post_rst_high", hi, 500);
        chk("post_rst_low", lo, 500);

`ifdef NOTE_TONE_DUTY_EN
        load(4'd9, 2'd0, 2'd1, w);
        wait_tick(n);
        meas(hi, lo);
        chk("duty25_high", hi, 250);
        chk("duty25_low", lo, 750);
        load(4'd9, 2'd0, 2'd3, w);
        wait_tick(n);
        meas(hi, lo);
        chk("duty75_high", hi, 750);
        chk("duty75_low", lo, 250);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
